hall_call_dispatcher: RTL and testbench

Upstream stage of the lift controller. It debounces and latches the 11 raw hall-call buttons (floors 0..10), holds the pending calls and lamps, and serializes them into the lift's 4-bit floor-request input as single-cycle pulses. Pending calls are cancelled when the lift stands stationary at the called floor. It consumes the lift's liftState and motor_signal outputs.

---
 rtl/hall_call_dispatcher.sv | 189 ++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_dispatcher.sv
// Hall-call front end: debounces the hall buttons, holds pending calls and lamps,
// and serializes eligible calls into single-cycle floor requests for the lift.
module hall_call_dispatcher #(
  parameter int                  NUM_FLOORS      = 11,
  parameter int                  FLOOR_W         = 4,
  parameter logic [FLOOR_W-1:0]  IDLE_CODE       = 4'hF,
  parameter int                  DEBOUNCE_CYCLES = 3,
  parameter int                  SERVICE_HOLD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] hall_btn,
  input  logic [FLOOR_W-1:0]    lift_floor,
  input  logic [1:0]            lift_motor,
  output logic [FLOOR_W-1:0]    floorReq,
  output logic [NUM_FLOORS-1:0] hall_lamp,
  output logic                  req_busy
);

  localparam int                 DCNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int                 SCNT_W  = $clog2(SERVICE_HOLD + 1);
  localparam logic [DCNT_W-1:0]  DEB_MAX = DCNT_W'(DEBOUNCE_CYCLES);
  localparam logic [SCNT_W-1:0]  SRV_MAX = SCNT_W'(SERVICE_HOLD);
  localparam logic [FLOOR_W-1:0] FLOORS  = FLOOR_W'(NUM_FLOORS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  logic [DCNT_W-1:0]     deb_cnt_r [NUM_FLOORS];
  logic [DCNT_W-1:0]     deb_cnt_s [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] deb_lvl_r, deb_lvl_s, rise_s;
  logic [SCNT_W-1:0]     srv_cnt_r, srv_cnt_s;
  logic [FLOOR_W-1:0]    prev_floor_r;
  logic                  stat_s;
  logic [NUM_FLOORS-1:0] cancel_s;
  logic [NUM_FLOORS-1:0] pending_r, pending_s, issued_r, issued_s;
  logic [NUM_FLOORS-1:0] elig_s, sel_oh_s;
  logic                  issue_fire_s, found_s;
  state_t                state_r;
  logic [FLOOR_W-1:0]    sel_r, ptr_r, pick_s, floor_req_r;
  logic                  sel_vld_r;

  // Floor index advanced by offs, wrapping at NUM_FLOORS.
  function automatic logic [FLOOR_W-1:0] wrap_add(input logic [FLOOR_W-1:0] base, input int offs);
    logic [FLOOR_W:0] sum;
    sum = {1'b0, base} + (FLOOR_W+1)'(offs);
    if (sum >= (FLOOR_W+1)'(NUM_FLOORS)) begin
      sum = sum - (FLOOR_W+1)'(NUM_FLOORS);
    end
    return sum[FLOOR_W-1:0];
  endfunction

  // Per-floor debounce: saturating run length of high samples, rise detect
  always_comb begin
    deb_cnt_s = '{default: '0};
    deb_lvl_s = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (!hall_btn[f]) begin
        deb_cnt_s[f] = '0;
      end else if (deb_cnt_r[f] == DEB_MAX) begin
        deb_cnt_s[f] = DEB_MAX;
      end else begin
        deb_cnt_s[f] = deb_cnt_r[f] + DCNT_W'(1);
      end
      deb_lvl_s[f] = (deb_cnt_s[f] == DEB_MAX);
    end
    rise_s = deb_lvl_s & ~deb_lvl_r;
  end

  // Stationary-at-floor run length and the cancel mask it produces
  always_comb begin
    stat_s = (lift_motor == 2'b00) && (lift_floor < FLOORS) && (lift_floor == prev_floor_r);
    if (!stat_s) begin
      srv_cnt_s = '0;
    end else if (srv_cnt_r == SRV_MAX) begin
      srv_cnt_s = SRV_MAX;
    end else begin
      srv_cnt_s = srv_cnt_r + SCNT_W'(1);
    end
    cancel_s = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      cancel_s[f] = (srv_cnt_s == SRV_MAX) && (lift_floor == FLOOR_W'(f));
    end
  end

  // Round-robin pick from the pointer and qualification of the issue slot
  always_comb begin
    elig_s   = pending_r & ~issued_r;
    pick_s   = '0;
    found_s  = 1'b0;
    sel_oh_s = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (!found_s && elig_s[wrap_add(ptr_r, i)]) begin
        pick_s  = wrap_add(ptr_r, i);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      sel_oh_s[f] = (sel_r == FLOOR_W'(f));
    end
    // A call cancelled between SCAN and ISSUE is dropped silently.
    issue_fire_s = (state_r == ST_ISSUE) && sel_vld_r && (|(pending_r & sel_oh_s));
  end

  // Next pending/issued vectors; cancel overrides both set sources
  always_comb begin
    pending_s = (pending_r | rise_s) & ~cancel_s;
    if (issue_fire_s) begin
      issued_s = (issued_r | sel_oh_s) & ~cancel_s;
    end else begin
      issued_s = issued_r & ~cancel_s;
    end
  end

  // Debounce, service and call-state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_cnt_r    <= '{default: '0};
      deb_lvl_r    <= '0;
      srv_cnt_r    <= '0;
      prev_floor_r <= '0;
      pending_r    <= '0;
      issued_r     <= '0;
    end else begin
      deb_cnt_r    <= deb_cnt_s;
      deb_lvl_r    <= deb_lvl_s;
      srv_cnt_r    <= srv_cnt_s;
      prev_floor_r <= lift_floor;
      pending_r    <= pending_s;
      issued_r     <= issued_s;
    end
  end

  // Dispatch FSM with registered floor request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      sel_r       <= '0;
      sel_vld_r   <= 1'b0;
      ptr_r       <= '0;
      floor_req_r <= IDLE_CODE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          floor_req_r <= IDLE_CODE;
          if (|elig_s) begin
            state_r <= ST_SCAN;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SCAN: begin
          floor_req_r <= IDLE_CODE;
          sel_r       <= pick_s;
          sel_vld_r   <= found_s;
          state_r     <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (issue_fire_s) begin
            floor_req_r <= sel_r;
            ptr_r       <= wrap_add(sel_r, 1);
          end else begin
            floor_req_r <= IDLE_CODE;
          end
          state_r <= ST_GAP;
        end
        ST_GAP: begin
          floor_req_r <= IDLE_CODE;
          state_r     <= ST_IDLE;
        end
        default: begin
          floor_req_r <= IDLE_CODE;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign floorReq  = floor_req_r;
  assign hall_lamp = pending_r;
  assign req_busy  = (state_r != ST_IDLE);

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Self-checking bench for hall_call_dispatcher: directed scenarios plus a
// randomized run compared against a timeline-style reference model.
module tb_hall_call_dispatcher;

  localparam int NF = 11;

  logic          clk;
  logic          rst;
  logic [NF-1:0] hall_btn;
  logic [3:0]    lift_floor;
  logic [1:0]    lift_motor;
  logic [3:0]    floorReq;
  logic [NF-1:0] hall_lamp;
  logic          req_busy;

  int checks;
  int errors;

  hall_call_dispatcher dut (
    .clk        (clk),
    .rst        (rst),
    .hall_btn   (hall_btn),
    .lift_floor (lift_floor),
    .lift_motor (lift_motor),
    .floorReq   (floorReq),
    .hall_lamp  (hall_lamp),
    .req_busy   (req_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int            m_hold [NF];
  logic [NF-1:0] m_pend, m_iss;
  logic [3:0]    m_prev_floor;
  int            m_run;
  logic          m_slot;
  int            m_t0, m_sel, m_ptr, cyc;
  logic          m_sel_ok;
  logic [3:0]    m_req;

  task automatic model_reset();
    for (int f = 0; f < NF; f++) m_hold[f] = 0;
    m_pend = '0; m_iss = '0; m_prev_floor = 4'd0; m_run = 0;
    m_slot = 1'b0; m_t0 = 0; m_sel = 0; m_ptr = 0; cyc = 0;
    m_sel_ok = 1'b0; m_req = 4'hF;
  endtask

  // One clock of the model: dispatch runs in 4-edge slots (start, pick, issue, rest).
  task automatic model_step();
    logic [NF-1:0] op, oi, rise, canc;
    int k, fi;
    op = m_pend; oi = m_iss; rise = '0; canc = '0;
    cyc++;
    for (int f = 0; f < NF; f++) begin
      if (hall_btn[f]) begin
        if (m_hold[f] < 1000) m_hold[f]++;
      end else m_hold[f] = 0;
      if (m_hold[f] == 3) rise[f] = 1'b1;
    end
    if (lift_motor == 2'b00 && lift_floor < 4'd11 && lift_floor == m_prev_floor) begin
      if (m_run < 1000) m_run++;
    end else m_run = 0;
    m_prev_floor = lift_floor;
    if (m_run >= 2) canc[lift_floor] = 1'b1;
    m_req = 4'hF;
    if (!m_slot) begin
      if ((op & ~oi) != '0) begin m_slot = 1'b1; m_t0 = cyc; end
    end else begin
      k = cyc - m_t0;
      if (k == 1) begin
        m_sel_ok = 1'b0;
        for (int i = 0; i < NF; i++) begin
          fi = (m_ptr + i) % NF;
          if (!m_sel_ok && op[fi] && !oi[fi]) begin m_sel = fi; m_sel_ok = 1'b1; end
        end
      end else if (k == 2) begin
        if (m_sel_ok && op[m_sel]) begin
          m_req = 4'(m_sel); oi[m_sel] = 1'b1; m_ptr = (m_sel + 1) % NF;
        end
      end else m_slot = 1'b0;
    end
    m_pend = (op | rise) & ~canc;
    m_iss  = oi & ~canc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; hall_btn = '0; lift_floor = 4'd0; lift_motor = 2'b11;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0; hall_btn = '0; lift_floor = 4'd0; lift_motor = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if (floorReq !== 4'hF || hall_lamp !== '0 || req_busy !== 1'b0) begin
      errors++; $display("FAIL reset_hold: got req=%h lamp=%b busy=%b, expected F/0/0", floorReq, hall_lamp, req_busy);
    end
    rst = 1'b1;
    model_reset();
    for (int t = 0; t < 20; t++) begin
      tick();
      checks++;
      if (floorReq !== 4'hF || hall_lamp !== '0 || req_busy !== 1'b0) begin
        errors++; $display("FAIL reset_idle t=%0d: got req=%h lamp=%b busy=%b, expected F/0/0", t, floorReq, hall_lamp, req_busy);
      end
    end
  endtask

  task automatic test_debounce();
    do_reset();
    hall_btn[5] = 1'b1; tick(); tick(); hall_btn[5] = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (hall_lamp !== '0) begin errors++; $display("FAIL glitch_lamp: got %b expected 0", hall_lamp); end
    end
    hall_btn[5] = 1'b1;
    tick(); tick();
    checks++;
    if (hall_lamp[5] !== 1'b0) begin errors++; $display("FAIL deb_early: got %b expected 0", hall_lamp[5]); end
    tick();
    checks++;
    if (hall_lamp[5] !== 1'b1) begin errors++; $display("FAIL deb_lamp: got %b expected 1", hall_lamp[5]); end
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (floorReq !== ((t == 3) ? 4'd5 : 4'hF)) begin
        errors++; $display("FAIL deb_pulse t=%0d: got %h expected %h", t, floorReq, (t == 3) ? 4'd5 : 4'hF);
      end
    end
    hall_btn[5] = 1'b0;
  endtask

  task automatic test_round_robin();
    int pv[$];
    int pt[$];
    int exp_v[3];
    int exp_t[3];
    int got_v, got_t;
    exp_v = '{2, 7, 9};
    exp_t = '{6, 10, 14};
    do_reset();
    hall_btn[7] = 1'b1; hall_btn[2] = 1'b1; hall_btn[9] = 1'b1;
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (floorReq !== 4'hF) begin pv.push_back(int'(floorReq)); pt.push_back(t); end
      checks++;
      if (floorReq !== m_req || hall_lamp !== m_pend || req_busy !== m_slot) begin
        errors++; $display("FAIL rr_model t=%0d: got %h/%b/%b expected %h/%b/%b", t, floorReq, hall_lamp, req_busy, m_req, m_pend, m_slot);
      end
    end
    checks++;
    if (pv.size() != 3) begin errors++; $display("FAIL rr_count: got %0d pulses expected 3", pv.size()); end
    for (int i = 0; i < 3; i++) begin
      got_v = (i < pv.size()) ? pv[i] : -1;
      got_t = (i < pt.size()) ? pt[i] : -1;
      checks++;
      if (got_v != exp_v[i] || got_t != exp_t[i]) begin
        errors++; $display("FAIL rr_order[%0d]: got floor %0d at %0d expected floor %0d at %0d", i, got_v, got_t, exp_v[i], exp_t[i]);
      end
    end
    hall_btn = '0;
  endtask

  task automatic test_cancel();
    do_reset();
    lift_floor = 4'd4; lift_motor = 2'b11;
    hall_btn[4] = 1'b1; tick(); tick(); tick(); hall_btn[4] = 1'b0;
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (hall_lamp[4] !== 1'b1) begin errors++; $display("FAIL cancel_pass t=%0d: got %b expected 1", t, hall_lamp[4]); end
    end
    lift_motor = 2'b00;
    tick();
    checks++;
    if (hall_lamp[4] !== 1'b1) begin errors++; $display("FAIL cancel_first: got %b expected 1", hall_lamp[4]); end
    tick();
    checks++;
    if (hall_lamp[4] !== 1'b0) begin errors++; $display("FAIL cancel_second: got %b expected 0", hall_lamp[4]); end
  endtask

  task automatic test_cancel_race();
    bit seen;
    do_reset();
    lift_floor = 4'd3; lift_motor = 2'b11;
    hall_btn[3] = 1'b1; tick(); tick(); tick(); hall_btn[3] = 1'b0;
    checks++;
    if (hall_lamp[3] !== 1'b1) begin errors++; $display("FAIL race_set: got %b expected 1", hall_lamp[3]); end
    lift_motor = 2'b00;
    tick();
    checks++;
    if (hall_lamp[3] !== 1'b1 || req_busy !== 1'b1) begin errors++; $display("FAIL race_scan: got lamp=%b busy=%b expected 1/1", hall_lamp[3], req_busy); end
    tick();
    checks++;
    if (hall_lamp[3] !== 1'b0) begin errors++; $display("FAIL race_cancel: got %b expected 0", hall_lamp[3]); end
    tick();
    checks++;
    if (floorReq !== 4'hF || req_busy !== 1'b1) begin errors++; $display("FAIL race_issue: got req=%h busy=%b expected F/1", floorReq, req_busy); end
    hall_btn[3] = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if (hall_lamp[3] !== 1'b0 || floorReq !== 4'hF) begin errors++; $display("FAIL race_press t=%0d: got lamp=%b req=%h expected 0/F", t, hall_lamp[3], floorReq); end
    end
    hall_btn[3] = 1'b0; lift_floor = 4'd0; lift_motor = 2'b11;
    tick();
    hall_btn[3] = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (floorReq == 4'd3) seen = 1'b1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL race_repress: got no pulse for floor 3 expected one"); end
    hall_btn = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    hall_btn[6] = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    checks++;
    if (req_busy !== 1'b1 || floorReq !== 4'hF || hall_lamp[6] !== 1'b1) begin
      errors++; $display("FAIL ar_pre: got busy=%b req=%h lamp=%b expected 1/F/1", req_busy, floorReq, hall_lamp[6]);
    end
    #2;
    rst = 1'b0; hall_btn = '0;
    #1;
    checks++;
    if (floorReq !== 4'hF || hall_lamp !== '0 || req_busy !== 1'b0) begin
      errors++; $display("FAIL ar_now: got req=%h lamp=%b busy=%b expected F/0/0", floorReq, hall_lamp, req_busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int t = 0; t < 6; t++) begin
      tick();
      checks++;
      if (floorReq !== 4'hF || hall_lamp !== '0 || req_busy !== 1'b0) begin
        errors++; $display("FAIL ar_after t=%0d: got req=%h lamp=%b busy=%b expected F/0/0", t, floorReq, hall_lamp, req_busy);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      for (int f = 0; f < NF; f++) begin
        if ($urandom_range(0, 29) == 0) hall_btn[f] = ~hall_btn[f];
      end
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: lift_motor = 2'b00;
          1: lift_motor = 2'b11;
          default: lift_motor = 2'b10;
        endcase
      end
      if (lift_motor == 2'b11 && lift_floor < 4'd12 && $urandom_range(0, 2) == 0) lift_floor = lift_floor + 4'd1;
      else if (lift_motor == 2'b10 && lift_floor > 4'd0 && $urandom_range(0, 2) == 0) lift_floor = lift_floor - 4'd1;
      tick();
      checks++;
      if (floorReq !== m_req) begin errors++; $display("FAIL rnd_req n=%0d: got %h expected %h", n, floorReq, m_req); end
      checks++;
      if (hall_lamp !== m_pend) begin errors++; $display("FAIL rnd_lamp n=%0d: got %b expected %b", n, hall_lamp, m_pend); end
      checks++;
      if (req_busy !== m_slot) begin errors++; $display("FAIL rnd_busy n=%0d: got %b expected %b", n, req_busy, m_slot); end
    end
    hall_btn = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; hall_btn = '0; lift_floor = 4'd0; lift_motor = 2'b11;
    model_reset();
    test_reset();
    test_debounce();
    test_round_robin();
    test_cancel();
    test_cancel_race();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
